// File: rtl/fc_layer_seq_if.sv
// Stream bundle for fc_layer_seq: input element stream in, neuron result stream out.
// master = environment side (upstream producer + downstream consumer), slave = sequencer side.
interface fc_layer_seq_if #(
  parameter int WIDTH = 8,
  parameter int ZW    = 22,
  parameter int OUT   = 10
);
  localparam int SW = $clog2(OUT);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ZW-1:0]    out_data;
  logic [SW-1:0]    out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/fc_layer_seq.sv
// Sequencer for a combinational fully-connected neuron bank: loads a streamed vector, then
// steps neuron_sel and streams each settled result out. Optional argmax tracking under FC_ARGMAX_EN.
module fc_layer_seq #(
  parameter int WIDTH  = 8,
  parameter int IN     = 84,
  parameter int OUT    = 10,
  parameter int ZW     = 22,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fc_layer_seq_if.slave           bus,
  output logic [IN*WIDTH-1:0]     x_bus,
  output logic [$clog2(OUT)-1:0]  neuron_sel,
  input  logic [ZW-1:0]           z_in,
  output logic                    busy
`ifdef FC_ARGMAX_EN
  ,
  output logic [$clog2(OUT)-1:0]  argmax_idx,
  output logic                    argmax_valid
`endif
);

  localparam int SW  = $clog2(OUT);
  localparam int CW  = $clog2(IN);
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_EMIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [SCW-1:0]   scnt_q;
  logic [WIDTH-1:0] x_q [IN];

  logic accept, last_beat, capture, drain;

  assign bus.in_ready = (state_q == S_LOAD);
  assign busy         = (state_q != S_LOAD);

  assign accept    = bus.in_valid && (state_q == S_LOAD);
  assign last_beat = accept && (cnt_q == CW'(IN - 1));
  assign capture   = (state_q == S_SETTLE) && (scnt_q == '0);
  assign drain     = (state_q == S_EMIT) && bus.out_ready;

  for (genvar k = 0; k < IN; k++) begin : g_xbus
    assign x_bus[k*WIDTH +: WIDTH] = x_q[k];
  end

  // NOTE: state_d gets its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (last_beat) state_d = S_SETTLE;
      S_SETTLE: if (capture)   state_d = S_EMIT;
      S_EMIT:   if (drain)     state_d = bus.out_last ? S_LOAD : S_SETTLE;
      default:  state_d = S_LOAD;
    endcase
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      scnt_q        <= '0;
      neuron_sel    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      // NOTE: the vector store is flops, not RAM, and is cleared so x_bus reads zero out of reset.
      for (int i = 0; i < IN; i++) x_q[i] <= '0;
    end else begin
      if (accept) begin
        x_q[cnt_q] <= bus.in_data;
        cnt_q      <= last_beat ? '0 : cnt_q + 1'b1;
      end
      if (last_beat) begin
        neuron_sel <= '0;
        scnt_q     <= SCW'(SETTLE - 1);
      end
      if ((state_q == S_SETTLE) && !capture) scnt_q <= scnt_q - 1'b1;
      // z_in has been stable for SETTLE edges here, so it is safe to sample.
      if (capture) begin
        bus.out_data  <= z_in;
        bus.out_idx   <= neuron_sel;
        bus.out_last  <= (neuron_sel == SW'(OUT - 1));
        bus.out_valid <= 1'b1;
      end
      if (drain) begin
        bus.out_valid <= 1'b0;
        if (!bus.out_last) begin
          neuron_sel <= neuron_sel + 1'b1;
          scnt_q     <= SCW'(SETTLE - 1);
        end
      end
    end
  end

`ifdef FC_ARGMAX_EN
  logic [ZW-1:0] max_q;
  logic [SW-1:0] run_idx_q;

  // Strict compare keeps the lowest index on ties; index 0 always seeds the running max.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q        <= '0;
      run_idx_q    <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= 1'b0;
      if (capture && ((neuron_sel == '0) || (z_in > max_q))) begin
        max_q     <= z_in;
        run_idx_q <= neuron_sel;
      end
      if (drain && bus.out_last) begin
        argmax_valid <= 1'b1;
        argmax_idx   <= run_idx_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: random vectors and handshakes, a stub neuron bank on z_in,
// and a reference model computing each neuron's result directly from the streamed vector.
module tb_fc_layer_seq;
  localparam int WIDTH  = 8;
  localparam int IN     = 84;
  localparam int OUT    = 10;
  localparam int ZW     = 22;
  localparam int SETTLE = 2;
  localparam int SW     = $clog2(OUT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_layer_seq_if #(.WIDTH(WIDTH), .ZW(ZW), .OUT(OUT)) bus ();

  logic [IN*WIDTH-1:0] x_bus;
  logic [SW-1:0]       neuron_sel;
  logic [ZW-1:0]       z_in;
  logic                busy;
`ifdef FC_ARGMAX_EN
  logic [SW-1:0]       argmax_idx;
  logic                argmax_valid;
`endif

  fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .ZW(ZW), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .x_bus        (x_bus),
    .neuron_sel   (neuron_sel),
    .z_in         (z_in),
    .busy         (busy)
`ifdef FC_ARGMAX_EN
    ,
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
`endif
  );

  typedef struct {
    logic [ZW-1:0] data;
    logic [SW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t      exp_q[$];
  int         am_q[$];
  beat_t      e;
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         t_last = 0;
  int         last_pop = 0;
  bit         lat_pending = 1'b0;
  bit         gap_pending = 1'b0;
  bit         first_vec = 1'b1;
  bit         stalled = 1'b0;
  logic [WIDTH-1:0] vec [IN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int wgt(input int k, input int j);
    return ((k * 3 + j * 7) % 11) + 1;
  endfunction

  // Stub neuron bank: weighted sum of x plus a per-neuron bias, always non-negative.
  always_comb begin
    int s;
    s = 100 * (int'(neuron_sel) + 1);
    for (int k = 0; k < IN; k++) s += int'(x_bus[k*WIDTH +: WIDTH]) * wgt(k, int'(neuron_sel));
    z_in = s[ZW-1:0];
  end

  // Streams one vector; abort_at >= 0 asserts rst once that many beats have been accepted.
  task automatic send_vector(input int abort_at, input bit ramp);
    int idx = 0;
    int guard = 0;
    int best = 0;
    int best_j = 0;
    logic [IN*WIDTH-1:0] exp_x;
    for (int k = 0; k < IN; k++) vec[k] = ramp ? WIDTH'(k + 1) : WIDTH'($urandom);
    while (idx < IN) begin
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (x_bus === '0) passes++;
        else $display("FAIL x_bus_after_abort: got %h expected 0", x_bus);
        check("in_ready_after_abort", bus.in_ready, 1);
        check("out_valid_after_abort", bus.out_valid, 0);
        return;
      end
      if (bus.in_ready) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = vec[idx];
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
      end
      @(posedge clk);
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        if (idx == IN) t_last = cyc;
      end
      guard++;
      if (guard > 5000) begin
        check("load_timeout_beats", idx, IN);
        return;
      end
    end
    for (int j = 0; j < OUT; j++) begin
      beat_t b;
      int s = 100 * (j + 1);
      for (int k = 0; k < IN; k++) s += int'(vec[k]) * wgt(k, j);
      b.data = s[ZW-1:0];
      b.idx  = SW'(j);
      b.last = (j == OUT - 1);
      exp_q.push_back(b);
      if (j == 0 || s > best) begin
        best   = s;
        best_j = j;
      end
    end
    am_q.push_back(best_j);
    lat_pending = 1'b1;
    @(negedge clk);
    for (int k = 0; k < IN; k++) exp_x[k*WIDTH +: WIDTH] = vec[k];
    checks++;
    if (x_bus === exp_x) passes++;
    else $display("FAIL x_bus_loaded: got %h expected %h", x_bus, exp_x);
    check("busy_after_load", busy, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'($urandom);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      g++;
    end
    check("drain_left_in_queue", exp_q.size(), 0);
    repeat (SETTLE + 3) @(negedge clk);
    check("in_ready_after_drain", bus.in_ready, 1);
    check("busy_after_drain", busy, 0);
  endtask

  // Monitor: compares every presented result beat against the front of the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_with_empty_queue", bus.out_valid, 0);
      end else begin
        e = exp_q[0];
        if (lat_pending) begin
          check("first_result_latency", cyc - t_last, SETTLE + 1);
          lat_pending = 1'b0;
        end else if (gap_pending) begin
          check("result_gap", cyc - last_pop, SETTLE + 1);
        end
        gap_pending = 1'b0;
        check("out_data", bus.out_data, e.data);
        check("out_idx", bus.out_idx, e.idx);
        check("out_last", bus.out_last, e.last);
        check("neuron_sel_frozen", neuron_sel, e.idx);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          last_pop    = cyc;
          gap_pending = !e.last;
        end
      end
    end
  end

`ifdef FC_ARGMAX_EN
  bit av_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (argmax_valid) begin
        check("argmax_single_pulse", av_prev, 0);
        check("argmax_timing", cyc - last_pop, 1);
        if (am_q.size() == 0) check("argmax_valid_unexpected", argmax_valid, 0);
        else check("argmax_idx", argmax_idx, am_q.pop_front());
      end
      av_prev = argmax_valid;
    end
  end
`endif

  // Downstream: always ready on the first vector except a 20-cycle stall on idx 3, random afterwards.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (first_vec && !stalled && bus.out_valid && bus.out_idx == SW'(3)) begin
        bus.out_ready = 1'b0;
        stalled = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end else if (first_vec) begin
        bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_idx", bus.out_idx, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_neuron_sel", neuron_sel, 0);
    checks++;
    if (x_bus === '0) passes++;
    else $display("FAIL reset_x_bus: got %h expected 0", x_bus);
`ifdef FC_ARGMAX_EN
    check("reset_argmax_idx", argmax_idx, 0);
    check("reset_argmax_valid", argmax_valid, 0);
`endif
    rst = 1'b0;

    send_vector(-1, 1'b1);
    wait_drain();
    check("stall_seen", stalled, 1);
    first_vec = 1'b0;

    send_vector(40, 1'b0);
    send_vector(-1, 1'b0);
    for (int v = 0; v < 3; v++) send_vector(-1, 1'b0);
    wait_drain();
`ifdef FC_ARGMAX_EN
    check("argmax_left_in_queue", am_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
